ctrl_escritura_banco: RTL and testbench

- Write-back arbiter and hazard scoreboard for the 32x32 register bank (RR1/RR2 read, WriteReg/Writedata/Regwrite write).
- Shares the bank's single write port between two producers, ALU result (A) and memory load (M), using round-robin arbitration.
- Drives the bank's write port from registers.
- Tracks pending destination registers and raises stall toward issue logic on RAW/WAW hazards.

---
 rtl/ctrl_escritura_banco.sv | 128 ++++++++++++
 tb/tb_ctrl_escritura_banco.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_escritura_banco.sv
// Write-back arbiter for the register bank: round-robin between ALU and load
// producers, registered write port, and a busy scoreboard that drives issue stall.
module ctrl_escritura_banco #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   a_valid,
    input  logic [ADDR_W-1:0]      a_reg,
    input  logic [DATA_W-1:0]      a_data,
    output logic                   a_ready,
    input  logic                   m_valid,
    input  logic [ADDR_W-1:0]      m_reg,
    input  logic [DATA_W-1:0]      m_data,
    output logic                   m_ready,
    input  logic                   wb_hold,
    output logic [ADDR_W-1:0]      WriteReg,
    output logic [DATA_W-1:0]      Writedata,
    output logic                   Regwrite,
    input  logic                   iss_valid,
    input  logic [ADDR_W-1:0]      iss_reg,
    input  logic [ADDR_W-1:0]      rr1,
    input  logic [ADDR_W-1:0]      rr2,
    input  logic                   use1,
    input  logic                   use2,
    output logic                   stall,
    output logic [2**ADDR_W-1:0]   busy,
    output logic [CNT_W-1:0]       cnt_wb,
    output logic [CNT_W-1:0]       cnt_conf
);

    localparam int NREG = 2**ADDR_W;

    logic                last_a_q;
    logic                regwrite_q;
    logic [ADDR_W-1:0]   wreg_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [NREG-1:0]     busy_q, busy_d;
    logic [CNT_W-1:0]    cnt_wb_q, cnt_wb_d;
    logic [CNT_W-1:0]    cnt_conf_q, cnt_conf_d;

    logic                gnt_a, gnt_m, xfer, wr_en, iss_set;
    logic [ADDR_W-1:0]   win_reg;
    logic [DATA_W-1:0]   win_data;

    // Grants are void during reset so nothing lands in the bank afterwards.
    always_comb begin
        gnt_a = 1'b0;
        gnt_m = 1'b0;
        if (!rst && !wb_hold) begin
            if (a_valid && m_valid) begin
                gnt_a = !last_a_q;
                gnt_m = last_a_q;
            end else begin
                gnt_a = a_valid;
                gnt_m = m_valid;
            end
        end
    end

    always_comb begin
        xfer     = gnt_a | gnt_m;
        win_reg  = gnt_a ? a_reg  : m_reg;
        win_data = gnt_a ? a_data : m_data;
        wr_en    = xfer && (win_reg != '0);
    end

    always_comb begin
        stall = iss_valid && ((use1 && busy_q[rr1]) ||
                              (use2 && busy_q[rr2]) ||
                              busy_q[iss_reg]);
        iss_set = iss_valid && !stall && (iss_reg != '0);
    end

    // Set after clear: a new producer claims the register over the retiring one.
    always_comb begin
        busy_d = busy_q;
        if (wr_en)
            busy_d[win_reg] = 1'b0;
        if (iss_set)
            busy_d[iss_reg] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        cnt_wb_d = cnt_wb_q;
        if (wr_en && (cnt_wb_q != '1))
            cnt_wb_d = cnt_wb_q + CNT_W'(1);
        cnt_conf_d = cnt_conf_q;
        if (a_valid && m_valid && (cnt_conf_q != '1))
            cnt_conf_d = cnt_conf_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_a_q   <= 1'b0;
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
            busy_q     <= '0;
            cnt_wb_q   <= '0;
            cnt_conf_q <= '0;
        end else begin
            regwrite_q <= wr_en;
            if (wr_en) begin
                wreg_q  <= win_reg;
                wdata_q <= win_data;
            end
            if (xfer)
                last_a_q <= gnt_a;
            busy_q     <= busy_d;
            cnt_wb_q   <= cnt_wb_d;
            cnt_conf_q <= cnt_conf_d;
        end
    end

    assign a_ready   = gnt_a;
    assign m_ready   = gnt_m;
    assign Regwrite  = regwrite_q;
    assign WriteReg  = wreg_q;
    assign Writedata = wdata_q;
    assign busy      = busy_q;
    assign cnt_wb    = cnt_wb_q;
    assign cnt_conf  = cnt_conf_q;

endmodule

// File: tb/tb_ctrl_escritura_banco.sv
// Bench for ctrl_escritura_banco: directed scenarios followed by random traffic,
// all compared against a cycle-level behavioural model of the write-back rules.
module tb_ctrl_escritura_banco;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid, m_valid, wb_hold;
    logic [AW-1:0] a_reg, m_reg, iss_reg, rr1, rr2;
    logic [DW-1:0] a_data, m_data;
    logic          a_ready, m_ready, Regwrite, iss_valid, use1, use2, stall;
    logic [AW-1:0] WriteReg;
    logic [DW-1:0] Writedata;
    logic [31:0]   busy;
    logic [CW-1:0] cnt_wb, cnt_conf;

    ctrl_escritura_banco #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
        .m_valid(m_valid), .m_reg(m_reg), .m_data(m_data), .m_ready(m_ready),
        .wb_hold(wb_hold),
        .WriteReg(WriteReg), .Writedata(Writedata), .Regwrite(Regwrite),
        .iss_valid(iss_valid), .iss_reg(iss_reg), .rr1(rr1), .rr2(rr2),
        .use1(use1), .use2(use2), .stall(stall), .busy(busy),
        .cnt_wb(cnt_wb), .cnt_conf(cnt_conf)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: who won last, which registers await a write, what the bank sees.
    bit          last_was_a;
    bit [31:0]   pend;
    bit          exp_rw;
    logic [4:0]  exp_wreg;
    logic [31:0] exp_wdata;
    int          writes_done, conflicts;
    bit          granted_a, granted_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        last_was_a  = 1'b0;
        pend        = '0;
        exp_rw      = 1'b0;
        exp_wreg    = '0;
        exp_wdata   = '0;
        writes_done = 0;
        conflicts   = 0;
    endtask

    // One clock: check combinational and registered outputs mid-cycle, then advance the model.
    task automatic step();
        bit          ea, em, est;
        logic [4:0]  r;
        logic [31:0] d;
        @(negedge clk);
        ea = 1'b0;
        em = 1'b0;
        if (!rst && !wb_hold) begin
            if (a_valid && m_valid) begin
                ea = !last_was_a;
                em = last_was_a;
            end else begin
                ea = a_valid;
                em = m_valid;
            end
        end
        est = iss_valid && ((use1 && pend[rr1]) || (use2 && pend[rr2]) || pend[iss_reg]);
        chk("a_ready", a_ready, ea);
        chk("m_ready", m_ready, em);
        chk("stall", stall, est);
        chk("Regwrite", Regwrite, exp_rw);
        if (exp_rw) begin
            chk("WriteReg", WriteReg, exp_wreg);
            chk("Writedata", Writedata, exp_wdata);
        end
        chk("busy", busy, pend);
        chk("cnt_wb", cnt_wb, writes_done);
        chk("cnt_conf", cnt_conf, conflicts);
        granted_a = ea;
        granted_m = em;
        if (rst) begin
            model_reset();
        end else begin
            r = ea ? a_reg : m_reg;
            d = ea ? a_data : m_data;
            exp_rw = (ea || em) && (r != 0);
            if (ea || em)
                last_was_a = ea;
            if (exp_rw) begin
                exp_wreg  = r;
                exp_wdata = d;
                pend[r]   = 1'b0;
                if (writes_done < CMAX) writes_done++;
            end
            if (iss_valid && !est && iss_reg != 0)
                pend[iss_reg] = 1'b1;
            if (a_valid && m_valid && conflicts < CMAX) conflicts++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 0; m_valid = 0; wb_hold = 0; iss_valid = 0;
        a_reg = 0; m_reg = 0; a_data = 0; m_data = 0;
        iss_reg = 0; rr1 = 0; rr2 = 0; use1 = 0; use2 = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    // Random requesters honour the hold-stable rule but may withdraw an ungranted request.
    task automatic drive_rand();
        if (!(a_valid && !granted_a && $urandom_range(3) != 0)) begin
            a_valid = 1'($urandom_range(1));
            a_reg   = 5'($urandom_range(7));
            a_data  = $urandom;
        end
        if (!(m_valid && !granted_m && $urandom_range(3) != 0)) begin
            m_valid = 1'($urandom_range(1));
            m_reg   = 5'($urandom_range(7));
            m_data  = $urandom;
        end
        wb_hold   = ($urandom_range(7) == 0);
        iss_valid = 1'($urandom_range(1));
        iss_reg   = 5'($urandom_range(9));
        rr1       = 5'($urandom_range(9));
        rr2       = 5'($urandom_range(9));
        use1      = 1'($urandom_range(1));
        use2      = 1'($urandom_range(1));
        rst       = ($urandom_range(299) == 0);
    endtask

    initial begin
        model_reset();
        idle_inputs();
        rst = 1;
        do_reset();

        // Single ALU write
        a_valid = 1; a_reg = 3; a_data = 32'h1234;
        step();
        idle_inputs();
        chk("t1_rw", Regwrite, 1);
        chk("t1_wreg", WriteReg, 3);
        chk("t1_wdata", Writedata, 32'h1234);
        chk("t1_cnt", cnt_wb, 1);
        step();

        // Four-cycle tie after reset alternates starting with A
        do_reset();
        a_valid = 1; a_reg = 1; a_data = 32'hA000_0000;
        m_valid = 1; m_reg = 2; m_data = 32'hB000_0000;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_gnt_a", granted_a, (i % 2 == 0));
            if (granted_a) a_data = a_data + 1;
            if (granted_m) m_data = m_data + 1;
        end
        chk("t2_conf", cnt_conf, 4);
        chk("t2_wb", cnt_wb, 4);

        // Hold freezes grants; tie rule resumes afterwards
        wb_hold = 1;
        for (int i = 0; i < 3; i++) step();
        wb_hold = 0;
        step();
        chk("t3_first_a", granted_a, 1);
        chk("t3_conf", cnt_conf, 8);
        idle_inputs();
        step();

        // Load to register 0 is swallowed
        m_valid = 1; m_reg = 0; m_data = 32'hFFFF_FFFF;
        step();
        idle_inputs();
        chk("t4_rw", Regwrite, 0);
        chk("t4_busy0", busy[0], 0);
        step();

        // RAW on r5 until the load retires, then WAW on re-issue
        iss_valid = 1; iss_reg = 5;
        step();
        iss_reg = 9; rr1 = 5; use1 = 1;
        step();
        step();
        m_valid = 1; m_reg = 5; m_data = 32'h5555;
        step();
        m_valid = 0;
        step();
        chk("t5_unstall", granted_m, 0);
        iss_reg = 5; rr1 = 0; use1 = 0;
        step();
        step();
        chk("t5_waw", stall, 1);
        idle_inputs();
        step();

        // Same-cycle set and clear of r7, then reset with traffic in flight
        iss_valid = 1; iss_reg = 7; a_valid = 1; a_reg = 7; a_data = 32'h7777;
        step();
        chk("t6_busy7", busy[7], 1);
        a_reg = 4; m_valid = 1; m_reg = 6; iss_reg = 8; iss_valid = 1;
        step();
        rst = 1;
        step();
        step();
        rst = 0;
        idle_inputs();
        chk("t6_busy", busy, 0);
        chk("t6_rw", Regwrite, 0);
        chk("t6_cnt", cnt_wb, 0);
        step();

        for (int i = 0; i < 3000; i++) begin
            drive_rand();
            step();
        end
        rst = 0;
        idle_inputs();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
